// File: rtl/datapath_gray_param.sv
// Byte-serial R,G,B to weighted gray converter with programmable fixed-point coefficients,
// passthrough mode, sof resynchronisation and a backpressured output FIFO.
module datapath_gray_param #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int COEF_FRAC  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DEF_COEF_R = 77,
  parameter int DEF_COEF_G = 150,
  parameter int DEF_COEF_B = 29
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  output logic              busy_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sof_out,
  input  logic              busy_in,
  input  logic              cfg_passthrough,
  input  logic [COEF_W-1:0] cfg_coef_r,
  input  logic [COEF_W-1:0] cfg_coef_g,
  input  logic [COEF_W-1:0] cfg_coef_b,
  output logic              err_resync
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int RND_W  = ACC_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam logic [RND_W-1:0] RND_CONST = RND_W'(1) << (COEF_FRAC - 1);
  localparam logic [RND_W-1:0] SAT_MAX   = RND_W'({DATA_W{1'b1}});
  localparam logic [COEF_W-1:0] DEF_COEF [3] = '{COEF_W'(DEF_COEF_R), COEF_W'(DEF_COEF_G),
                                                 COEF_W'(DEF_COEF_B)};

  // phase_reg is one-hot: bit0 = R, bit1 = G, bit2 = B
  logic [2:0]        phase_reg;
  logic              pass_reg;
  logic              err_reg;
  logic [COEF_W-1:0] coef_reg [3];
  logic [COEF_W-1:0] coef_eff [3];
  logic [COEF_W-1:0] cfg_coef [3];
  logic [COEF_W-1:0] sel_coef;
  logic [PROD_W-1:0] product;
  logic [2:0]        eff_phase;
  logic              eff_pass;
  logic              accept;

  logic              s1_valid_reg, s1_first_reg, s1_last_reg, s1_pass_reg, s1_sof_reg;
  logic [PROD_W-1:0] s1_prod_reg;
  logic              s1_res;

  logic [ACC_W-1:0]  acc_reg;
  logic              res_valid_reg, res_sof_reg, res_pass_reg, pix_sof_reg;

  logic [RND_W-1:0]  rnd_sum, rnd_shift;
  logic [DATA_W-1:0] gray_val;
  logic [DATA_W:0]   wr_data;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              fifo_nonempty, out_load, fifo_rd;
  logic [OCC_W-1:0]  occupancy;

  assign cfg_coef[0] = cfg_coef_r;
  assign cfg_coef[1] = cfg_coef_g;
  assign cfg_coef[2] = cfg_coef_b;

  assign accept    = valid_in && !busy_out;
  // A sof byte is always an R byte and already runs with the incoming configuration.
  assign eff_phase = sof_in ? 3'b001 : phase_reg;
  assign eff_pass  = sof_in ? cfg_passthrough : pass_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_coef
    assign coef_eff[gi] = sof_in ? cfg_coef[gi] : coef_reg[gi];
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        coef_reg[gi] <= DEF_COEF[gi];
      end else if (accept && sof_in) begin
        coef_reg[gi] <= cfg_coef[gi];
      end
    end
  end

  always_comb begin
    sel_coef = '0;
    for (int i = 0; i < 3; i++) begin
      if (eff_phase[i]) sel_coef = sel_coef | coef_eff[i];
    end
  end

  assign product = PROD_W'(data_in) * PROD_W'(sel_coef);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_reg <= 3'b001;
      pass_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= accept && sof_in && !phase_reg[0];
      if (accept) begin
        phase_reg <= {eff_phase[1], eff_phase[0], eff_phase[2]};
        if (sof_in) pass_reg <= cfg_passthrough;
      end
    end
  end

  assign err_resync = err_reg;

  // S1: product (or raw byte in passthrough) with pixel-position tags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_pass_reg  <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_prod_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_prod_reg  <= eff_pass ? PROD_W'(data_in) : product;
        s1_first_reg <= eff_phase[0];
        s1_last_reg  <= eff_phase[2];
        s1_pass_reg  <= eff_pass;
        s1_sof_reg   <= sof_in;
      end
    end
  end

  assign s1_res = s1_valid_reg && (s1_pass_reg || s1_last_reg);

  // S2: an R byte reloads the accumulator, which also drops any partial pixel left by a resync
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_reg       <= '0;
      res_valid_reg <= 1'b0;
      res_sof_reg   <= 1'b0;
      res_pass_reg  <= 1'b0;
      pix_sof_reg   <= 1'b0;
    end else begin
      res_valid_reg <= s1_res;
      if (s1_valid_reg) begin
        if (s1_pass_reg || s1_first_reg) acc_reg <= ACC_W'(s1_prod_reg);
        else                             acc_reg <= acc_reg + ACC_W'(s1_prod_reg);
        if (s1_first_reg) pix_sof_reg <= s1_sof_reg;
        if (s1_res) begin
          res_sof_reg  <= s1_pass_reg ? s1_sof_reg : pix_sof_reg;
          res_pass_reg <= s1_pass_reg;
        end
      end
    end
  end

  // S3: round to nearest, saturate, and write into the FIFO
  always_comb begin
    rnd_sum   = RND_W'(acc_reg) + RND_CONST;
    rnd_shift = rnd_sum >> COEF_FRAC;
    gray_val  = (rnd_shift > SAT_MAX) ? {DATA_W{1'b1}} : rnd_shift[DATA_W-1:0];
    wr_data   = {res_sof_reg, res_pass_reg ? acc_reg[DATA_W-1:0] : gray_val};
  end

  always_ff @(posedge i_clk) begin
    if (res_valid_reg) fifo_mem[wr_ptr_reg] <= wr_data;
  end

  assign fifo_nonempty = (count_reg != '0);
  assign out_load      = !valid_out || !busy_in;
  assign fifo_rd       = out_load && fifo_nonempty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (res_valid_reg) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (fifo_rd)       rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({res_valid_reg, fifo_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output register doubles as the registered read port of the FIFO memory
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_out  <= '0;
      sof_out   <= 1'b0;
      valid_out <= 1'b0;
    end else if (out_load) begin
      valid_out <= fifo_nonempty;
      if (fifo_nonempty) {sof_out, data_out} <= fifo_mem[rd_ptr_reg];
    end
  end

  // Every result already in flight is guaranteed a FIFO slot, so stall one entry early.
  assign occupancy = OCC_W'(count_reg) + OCC_W'(s1_res) + OCC_W'(res_valid_reg);
  assign busy_out  = (occupancy >= OCC_W'(FIFO_DEPTH - 1));

endmodule

// File: doc/datapath_gray_param.md
Name: datapath_gray_param

Overview:
- Parametrised successor to the fixed 8-bit RGB-to-gray datapath.
- Consumes a byte-serial R,G,B sample stream and emits one weighted gray sample per pixel. Weights are programmable fixed-point coefficients, with round-to-nearest and saturation.
- Adds a passthrough mode, sof-based phase resynchronisation, and an output FIFO with true valid/busy backpressure, so no sample is ever dropped.
- Sits between the pixel source and downstream datapath stages on the same valid/sof/busy stream protocol.

Parameters:
- DATA_W, 8: sample width (input and output).
- COEF_W, 8: unsigned coefficient width.
- COEF_FRAC, 8: fractional bits of the coefficients; must satisfy 1 <= COEF_FRAC <= DATA_W+COEF_W.
- FIFO_DEPTH, 8: output FIFO entries; power of two, >= 4.
- DEF_COEF_R, 77: reset red coefficient.
- DEF_COEF_G, 150: reset green coefficient.
- DEF_COEF_B, 29: reset blue coefficient.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- data_in  in  DATA_W  input sample, order R,G,B per pixel
- valid_in  in  1  data_in valid
- sof_in  in  1  start of frame, qualifies the R sample of a frame's first pixel
- busy_out  out  1  block cannot accept input this cycle
- data_out  out  DATA_W  output sample
- valid_out  out  1  data_out valid
- sof_out  out  1  first output sample of frame
- busy_in  in  1  downstream cannot accept
- cfg_passthrough  in  1  0 = gray, 1 = forward every input sample unchanged
- cfg_coef_r / cfg_coef_g / cfg_coef_b  in  COEF_W each  coefficients
- err_resync  out  1  one-cycle pulse when sof_in arrives mid-pixel

Behaviour:
- Input accept: valid_in && !busy_out at a rising edge. Output transfer: valid_out && !busy_in.
- Reset values: data_out=0, valid_out=0, sof_out=0, err_resync=0, busy_out=0. Reset also:
  - sets phase to R;
  - clears the FIFO and the pipeline;
  - sets active mode to gray and active coefficients to DEF_COEF_*.
- Reset asserted mid-frame discards any partial pixel and all queued results.
- Config latch: cfg_passthrough and cfg_coef_* are sampled only on an accepted byte with sof_in=1. That byte already uses the new values. Changes elsewhere are ignored.
- Phase counter (one-hot R->G->B->R) advances only on accepted bytes; it never advances on stall.
- Resync on sof_in=1 when phase != R:
  - the byte is treated as R of a new pixel;
  - the partial pixel is discarded (no output);
  - err_resync pulses for 1 cycle.
- Gray pipeline:
  - S1 registers product = data_in * coef[phase], width DATA_W+COEF_W.
  - S2 accumulator, width DATA_W+COEF_W+2: loads on R, adds on G/B, and marks a result on B.
  - S3 computes (acc + 2^(COEF_FRAC-1)) >> COEF_FRAC, saturates to 2^DATA_W-1, and writes the FIFO with the sof flag of the pixel's R byte.
- Passthrough: every accepted byte travels S1..S3 unchanged and is written to the FIFO. sof_out marks the byte accepted with sof_in.
- Latency:
  - Gray: B byte accepted at edge N, FIFO write at edge N+2, valid_out=1 after edge N+3 (FIFO empty, busy_in=0).
  - Passthrough: the same timing applies per byte.
- Output register: loads from the FIFO head when !valid_out || !busy_in. data_out, sof_out and valid_out are held stable while valid_out && busy_in. FIFO write and read in the same cycle are allowed; count is unchanged.
- busy_out is combinational and equals (fifo_count + results in S1..S3) >= FIFO_DEPTH-1.
  - This guarantees the FIFO never overflows.
  - busy_out does not depend on valid_in.
- Empty FIFO with busy_in=0: there are no bubbles beyond the pipeline latency.

Test Plan:
- Defaults, gray mode:
  - pixel R=255,G=0,B=0 -> data_out=77;
  - R=G=B=255 -> 255;
  - R=G=B=0 -> 0;
  - B accepted at edge N -> valid_out high after edge N+3.
- Saturation: sof pixel with cfg_coef_r/g/b=255/255/255 and R=G=B=255 -> raw 762 -> data_out=255, sof_out=1.
- Backpressure:
  - hold busy_in=1 and stream 20 pixels -> busy_out asserts once fifo+inflight reaches 7 and the FIFO never overflows;
  - release busy_in -> all pixels emerge in order with none lost, and data_out is held stable during the stall.
- Resync: send R,G, then sof_in=1 with bytes 10,20,30 (coefs 77/150/29) -> err_resync pulses once, the partial pixel is dropped, the output is (770+3000+870+128)>>8=18 with sof_out=1.
- Mode change: cfg_passthrough=1 driven mid-frame -> ignored. Taking effect at the next sof: bytes 5,6,7 -> data_out 5,6,7 with sof_out on 5.
- Reset mid-frame with 3 results queued -> valid_out=0 and busy_out=0 the next cycle, and the next pixel uses DEF_COEF_*.
